// File: rtl/imem_fetch_if.sv
// Fetch-side bus bundle: imem read port plus the instruction handshake to decode.
//   master (fetch controller): drives imem_addr, instr, instr_pc, instr_valid;
//                              samples imem_q, instr_ready.
//   slave  (imem + decode)   : the opposite directions.
interface imem_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_q;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH+1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;

  modport master (
    output imem_addr, instr, instr_pc, instr_valid,
    input  imem_q, instr_ready
  );

  modport slave (
    input  imem_addr, instr, instr_pc, instr_valid,
    output imem_q, instr_ready
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: holds the fetch PC, reads the combinational imem
// every cycle and buffers fetched words in a small prefetch FIFO presented to
// decode with valid/ready.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start, halt         - run control pulses (halt wins when both are high)
//   redirect_valid/_pc  - load new fetch PC (byte address) and flush the FIFO
//   busy, done          - state==RUN / state==DONE
//   bus (master)        - imem_addr/imem_q and instr/instr_pc/instr_valid/instr_ready
// Build option: define FETCH_WRAP_EN to wrap fetch_pc past the last word
// instead of stopping in DONE.
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH+1:0] redirect_pc,
  output logic                  busy,
  output logic                  done,
  imem_fetch_if.master          bus
);

  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;
  localparam logic [ADDR_WIDTH-1:0] LAST_PC = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [CNT_W-1:0]       count, cnt_nxt, cnt_left;
  logic [PTR_W-1:0]       rd_ptr, wr_ptr, rd_nxt;
  logic [DATA_WIDTH-1:0]  q_data [2**PTR_W];
  logic [ADDR_WIDTH-1:0]  q_pc   [2**PTR_W];
  logic [DATA_WIDTH-1:0]  instr_q;
  logic [ADDR_WIDTH+1:0]  instr_pc_q;
  logic                   instr_valid_q;
  logic                   deq, fetch;
  logic                   unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  assign bus.imem_addr   = fetch_pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, fetch/dequeue decisions and FIFO bookkeeping
  always_comb begin
    state_nxt = state;
    deq       = instr_valid_q && bus.instr_ready;
    fetch     = (state == S_RUN) && !redirect_valid &&
                ((count < CNT_W'(QDEPTH)) || deq);
    cnt_left  = count - CNT_W'(deq);
    cnt_nxt   = cnt_left + CNT_W'(fetch);
    rd_nxt    = deq ? ptr_inc(rd_ptr) : rd_ptr;
    case (state)
      S_IDLE, S_HALT: if (start && !halt) state_nxt = S_RUN;
      S_RUN: begin
`ifdef FETCH_WRAP_EN
        if (halt) state_nxt = S_HALT;
`else
        // Once the last word is fetched there is nothing left to resume.
        if (fetch && (fetch_pc == LAST_PC)) state_nxt = S_DONE;
        else if (halt)                      state_nxt = S_HALT;
`endif
      end
      S_DONE: if (redirect_valid) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fetch PC, prefetch FIFO and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc      <= '0;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int i = 0; i < 2**PTR_W; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      busy <= (state_nxt == S_RUN);
      done <= (state_nxt == S_DONE);
      if (redirect_valid) begin
        fetch_pc      <= redirect_pc[ADDR_WIDTH+1:2];
        count         <= '0;
        rd_ptr        <= '0;
        wr_ptr        <= '0;
        instr_valid_q <= 1'b0;
      end else begin
        if (fetch) begin
          q_data[wr_ptr] <= bus.imem_q;
          q_pc[wr_ptr]   <= fetch_pc;
          wr_ptr         <= ptr_inc(wr_ptr);
          fetch_pc       <= fetch_pc + ADDR_WIDTH'(1);
        end
        rd_ptr        <= rd_nxt;
        count         <= cnt_nxt;
        instr_valid_q <= (cnt_nxt != '0);
        // New head: the word being fetched if nothing older remains,
        // otherwise the stored entry at the next read pointer.
        if (fetch && (cnt_left == '0)) begin
          instr_q    <= bus.imem_q;
          instr_pc_q <= {fetch_pc, 2'b00};
        end else if (cnt_left != '0) begin
          instr_q    <= q_data[rd_nxt];
          instr_pc_q <= {q_pc[rd_nxt], 2'b00};
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl; imem model returns 32'hA000_0000 + addr.
module tb_imem_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic       busy, done;
  int         n_cmp = 0;
  int         n_err = 0;

  imem_fetch_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  assign bus.imem_q = 32'hA000_0000 + 32'(bus.imem_addr);

  imem_fetch_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .QDEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .done           (done),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] word);
    check_eq({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check_eq({tag, "_instr"}, bus.instr, 32'hA000_0000 + word);
    check_eq({tag, "_pc"}, 32'(bus.instr_pc), word << 2);
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    do_reset();
    check_eq("rst_valid", 32'(bus.instr_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_addr", 32'(bus.imem_addr), 0);
    check_eq("rst_instr", bus.instr, 0);
    check_eq("rst_pc", 32'(bus.instr_pc), 0);

    // Streaming with ready held high
    bus.instr_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check_eq("s_busy", 32'(busy), 1);
    check_eq("s_valid0", 32'(bus.instr_valid), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_head("stream", 32'(i));
    end

    // Backpressure: FIFO fills to two, head holds
    do_reset();
    bus.instr_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_head("bp_hold", 0);
    check_eq("bp_addr", 32'(bus.imem_addr), 2);
    bus.instr_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_head("bp_drain", 32'(i));
    end

    // Redirect while FIFO holds words 3,4
    do_reset();
    bus.instr_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    bus.instr_ready = 1'b1;
    tick(); tick(); tick();
    check_head("rd_pre", 3);
    redirect_valid = 1'b1; redirect_pc = 8'h20;
    tick(); redirect_valid = 1'b0;
    check_eq("rd_flush", 32'(bus.instr_valid), 0);
    check_eq("rd_addr", 32'(bus.imem_addr), 8);
    tick();
    check_head("rd_tgt", 8);
    tick();
    check_head("rd_tgt1", 9);

    // Halt with full FIFO, drain, resume
    do_reset();
    bus.instr_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    halt = 1'b1;
    tick(); halt = 1'b0;
    check_eq("h_busy", 32'(busy), 0);
    tick(); tick();
    check_eq("h_addr", 32'(bus.imem_addr), 2);
    check_head("h_hold", 0);
    bus.instr_ready = 1'b1;
    tick();
    check_head("h_drain", 1);
    tick();
    check_eq("h_empty", 32'(bus.instr_valid), 0);
    start = 1'b1; halt = 1'b1;
    tick(); start = 1'b0; halt = 1'b0;
    check_eq("h_haltwins", 32'(busy), 0);
    start = 1'b1;
    tick(); start = 1'b0;
    check_eq("h_resume_busy", 32'(busy), 1);
    tick();
    check_head("h_resume", 2);

    // Last word: DONE or wrap
    do_reset();
    bus.instr_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 8'hF8;
    tick(); redirect_valid = 1'b0;
    tick();
    check_head("end62", 62);
    check_eq("end62_done", 32'(done), 0);
    tick();
    check_head("end63", 63);
`ifdef FETCH_WRAP_EN
    check_eq("wrap_done63", 32'(done), 0);
    tick();
    check_head("wrap0", 0);
    tick();
    check_head("wrap1", 1);
    check_eq("wrap_done", 32'(done), 0);
    check_eq("wrap_busy", 32'(busy), 1);
`else
    check_eq("end_done63", 32'(done), 1);
    tick();
    check_eq("end_valid", 32'(bus.instr_valid), 0);
    check_eq("end_done", 32'(done), 1);
    check_eq("end_busy", 32'(busy), 0);
    tick();
    check_eq("end_valid2", 32'(bus.instr_valid), 0);
`endif
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    tick(); redirect_valid = 1'b0;
    check_eq("redo_busy", 32'(busy), 1);
    check_eq("redo_done", 32'(done), 0);
    tick();
    check_head("redo", 4);

    // Reset mid-run with full FIFO
    do_reset();
    bus.instr_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check_eq("mr_valid", 32'(bus.instr_valid), 0);
    check_eq("mr_busy", 32'(busy), 0);
    check_eq("mr_addr", 32'(bus.imem_addr), 0);
    check_eq("mr_instr", bus.instr, 0);
    reset = 1'b0; bus.instr_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check_head("mr_restart", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
